usb_bus_responder: RTL

- FPGA-side responder for the SAM3U parallel register bus (USB_A, USB_D, USB_nRD, USB_nWR, USB_nCE) driven by the host.
- Decodes each bus strobe into a single-cycle register read or write on the internal register bus consumed by the crypto, SRAM and LED register blocks.
- Owns the tristate direction of USB_D.
- Sits directly under cw310_top, between the pads and the register-decode blocks.

---
 rtl/usb_bus_responder_if.sv | 39 +++
 rtl/usb_bus_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_responder_if.sv
// Bus bundle between the SAM3U parallel register bus pads and the FPGA register blocks.
//   usb_addr/usb_din/usb_rdn/usb_wrn/usb_cen : host-driven bus (USB_A, USB_D in, nRD, nWR, nCE)
//   usb_dout/usb_isout                       : USB_D output path and its tristate enable
//   reg_*                                    : single-cycle internal register bus
//   bus_err                                  : sticky protocol error flag
// slave  : the responder side
// master : the host pads plus register blocks
interface usb_bus_responder_if #(
  parameter int unsigned pADDR_WIDTH   = 20,
  parameter int unsigned pBYTECNT_SIZE = 7
);
  logic [pADDR_WIDTH-1:0]               usb_addr;
  logic [7:0]                           usb_din;
  logic [7:0]                           usb_dout;
  logic                                 usb_isout;
  logic                                 usb_rdn;
  logic                                 usb_wrn;
  logic                                 usb_cen;
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
  logic [7:0]                           reg_datao;
  logic [7:0]                           reg_datai;
  logic                                 reg_addrvalid;
  logic                                 reg_read;
  logic                                 reg_write;
  logic                                 bus_err;

  modport slave (
    input  usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, reg_datai,
    output usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao,
           reg_addrvalid, reg_read, reg_write, bus_err
  );

  modport master (
    output usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, reg_datai,
    input  usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao,
           reg_addrvalid, reg_read, reg_write, bus_err
  );
endinterface

// File: rtl/usb_bus_responder.sv
// Responder for the SAM3U parallel register bus. Turns each host nRD/nWR strobe
// into one reg_read or reg_write pulse and owns the USB_D tristate direction.
// Ports:
//   usb_clk : bus and logic clock
//   resetn  : asynchronous active-low reset
//   bus     : usb_bus_responder_if.slave (USB pads side and register bus side)
// Optional feature macro: USB_BUS_ERR_EN
//   Adds a sticky bus_err flag and an 8-bit saturating violation counter that is
//   read back at register index 0x7F (a write to that index clears it).
//   Without it bus_err is tied low and index 0x7F is an ordinary register.
module usb_bus_responder #(
  parameter int unsigned pADDR_WIDTH   = 20,
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pREAD_LAT     = 2
) (
  input  logic                usb_clk,
  input  logic                resetn,
  usb_bus_responder_if.slave  bus
);

  localparam int unsigned IDX_W = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(pREAD_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRIVE = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // Input registers; the _q copies give the previous sample for edge detection.
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [7:0]             r_din;
  logic                   r_rdn, r_wrn, r_cen;
  logic                   r_rdn_q, r_wrn_q;

  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_din   <= '0;
      r_rdn   <= 1'b1;
      r_wrn   <= 1'b1;
      r_cen   <= 1'b1;
      r_rdn_q <= 1'b1;
      r_wrn_q <= 1'b1;
    end else begin
      r_addr  <= bus.usb_addr;
      r_din   <= bus.usb_din;
      r_rdn   <= bus.usb_rdn;
      r_wrn   <= bus.usb_wrn;
      r_cen   <= bus.usb_cen;
      r_rdn_q <= r_rdn;
      r_wrn_q <= r_wrn;
    end
  end

  logic fall_rd_c, fall_wr_c;
  assign fall_rd_c = r_rdn_q & ~r_rdn;
  assign fall_wr_c = r_wrn_q & ~r_wrn;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [7:0]         dout_q, dout_d;
  logic               isout_q, isout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [pBYTECNT_SIZE-1:0] bc_q, bc_d;
  logic [7:0]         datao_q, datao_d;
  logic               av_q, av_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic [7:0]         rd_data_c;

`ifdef USB_BUS_ERR_EN
  // Violation detection, sticky flag and saturating counter at index 0x7F.
  logic [pADDR_WIDTH-1:0] r_addr_q;
  logic                   err_q;
  logic [7:0]             err_cnt;
  logic                   both_now_c, both_prev_c, err_event_c, cnt_clr_c;

  assign both_now_c  = ~r_rdn & ~r_wrn;
  assign both_prev_c = ~r_rdn_q & ~r_wrn_q;
  // Each violation counts once: both-low on its onset, not every cycle it lasts.
  assign err_event_c = (both_now_c & ~both_prev_c)
                     | ((fall_rd_c | fall_wr_c) & r_cen)
                     | ((state == RD_DRIVE) && (r_addr != r_addr_q));
  assign cnt_clr_c   = write_q && (idx_q == IDX_W'(7'h7F));
  assign rd_data_c   = (idx_q == IDX_W'(7'h7F)) ? err_cnt : bus.reg_datai;

  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      r_addr_q <= '0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      r_addr_q <= r_addr;
      err_q    <= err_q | err_event_c;
      if (cnt_clr_c) begin
        err_cnt <= '0;
      end else if (err_event_c && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign bus.bus_err = err_q;
`else
  assign rd_data_c   = bus.reg_datai;
  assign bus.bus_err = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      dout_q  <= '0;
      isout_q <= 1'b0;
      idx_q   <= '0;
      bc_q    <= '0;
      datao_q <= '0;
      av_q    <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      dout_q  <= dout_d;
      isout_q <= isout_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      datao_q <= datao_d;
      av_q    <= av_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  // Next state and next output values; strobes default low so each is one cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dout_d  = dout_q;
    isout_d = isout_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    datao_d = datao_q;
    av_d    = av_q;
    read_d  = 1'b0;
    write_d = 1'b0;

    case (state)
      IDLE: begin
        av_d    = 1'b0;
        isout_d = 1'b0;
        // Write is checked first so simultaneous strobes resolve to a write.
        if (!r_cen && fall_wr_c) begin
          state_d = WRITE;
          idx_d   = r_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
          bc_d    = r_addr[pBYTECNT_SIZE-1:0];
          datao_d = r_din;
          av_d    = 1'b1;
          write_d = 1'b1;
        end else if (!r_cen && fall_rd_c) begin
          state_d = RD_WAIT;
          idx_d   = r_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
          bc_d    = r_addr[pBYTECNT_SIZE-1:0];
          av_d    = 1'b1;
          read_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        state_d = HOLD;
      end
      RD_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == WAIT_LAST) begin
          cnt_d = cnt;
          // A host that already let go of the bus is never driven.
          if (r_cen || r_rdn) begin
            state_d = HOLD;
          end else begin
            dout_d  = rd_data_c;
            isout_d = 1'b1;
            state_d = RD_DRIVE;
          end
        end
      end
      RD_DRIVE: begin
        if (r_rdn || r_cen) begin
          isout_d = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (r_rdn && r_wrn) begin
          av_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        isout_d = 1'b0;
        av_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.usb_dout      = dout_q;
  assign bus.usb_isout     = isout_q;
  assign bus.reg_address   = idx_q;
  assign bus.reg_bytecnt   = bc_q;
  assign bus.reg_datao     = datao_q;
  assign bus.reg_addrvalid = av_q;
  assign bus.reg_read      = read_q;
  assign bus.reg_write     = write_q;

endmodule
